// File: rtl/flex_pts_stream_pkg.sv
// Package shared by the flex_pts_stream parallel-to-serial shifter.
// Contents:
//   pts_state_t    FSM state encoding (IDLE, SHIFT, STUFF)
//   STUFF_RUN_LEN  length of a run of ones that forces a stuffed 0
//                  (only used when FLEX_PTS_BIT_STUFF_EN is defined)
package flex_pts_pkg;

    typedef enum logic [1:0] {
        PTS_IDLE  = 2'd0,
        PTS_SHIFT = 2'd1,
        PTS_STUFF = 2'd2
    } pts_state_t;

    localparam int STUFF_RUN_LEN = 6;

endpackage

// File: rtl/flex_pts_stream_if.sv
// Word-load handshake between the packet/byte sequencer (master) and the
// serialiser (slave).
// Signals:
//   load_valid   master -> slave  parallel_in holds a word
//   load_ready   slave -> master  word taken when load_valid && load_ready
//   parallel_in  master -> slave  NUM_BITS-wide word
interface flex_pts_stream_if #(
    parameter int NUM_BITS = 8
);
    logic                load_valid;
    logic                load_ready;
    logic [NUM_BITS-1:0] parallel_in;

    modport master (
        output load_valid,
        output parallel_in,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  parallel_in,
        output load_ready
    );
endinterface

// File: rtl/flex_pts_stream_stuff_ctrl.sv
// USB bit-stuffing run tracker for flex_pts_stream. Only instantiated when
// FLEX_PTS_BIT_STUFF_EN is defined.
// Ports:
//   clk, n_rst  clock, asynchronous active-low reset
//   count_en    a data bit is being emitted on this edge
//   bit_in      value of the data bit being emitted
//   stuff_clr   synchronous clear of the run counter (flush, idle, stuff consumed)
//   stuff_req   this edge completes a run of STUFF_RUN_LEN ones; the next
//               bit period must be a stuffed 0
module pts_stuff_ctrl
    import flex_pts_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic count_en,
    input  logic bit_in,
    input  logic stuff_clr,
    output logic stuff_req
);

    logic [2:0] run_cnt;

    assign stuff_req = count_en && bit_in && (run_cnt == 3'(STUFF_RUN_LEN - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run_cnt <= '0;
        end else if (stuff_clr) begin
            run_cnt <= '0;
        end else if (count_en) begin
            run_cnt <= bit_in ? run_cnt + 3'd1 : 3'd0;
        end
    end

endmodule

// File: rtl/flex_pts_stream.sv
// Parallel-to-serial shifter for the USB TX path (sequencer -> NRZI).
// Words arrive over a valid/ready handshake with a 1-entry hold buffer so
// back-to-back words serialise with no gap bits. One bit period is consumed
// per cycle with shift_enable high.
// Optional bit stuffing: define FLEX_PTS_BIT_STUFF_EN.
//
// Parameters:
//   NUM_BITS   word width (>= 2)
//   SHIFT_MSB  1: MSB first, 0: LSB first
//   IDLE_VAL   idle line level and fill bit for the vacated shift-reg end
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   clear         synchronous flush of shift reg, hold buffer and FSM
//   shift_enable  per-bit strobe
//   ld            word-load handshake (slave side)
//   serial_out    current bit
//   busy          not idle, or hold buffer occupied
//   word_done     1-cycle pulse after the last bit period of a word
//
// state     | meaning
// PTS_IDLE  | line at IDLE_VAL, waiting for a word
// PTS_SHIFT | data bits of the current word on serial_out
// PTS_STUFF | stuffed 0 on serial_out, data frozen (bit stuffing only)
module flex_pts_stream
    import flex_pts_pkg::*;
#(
    parameter int   NUM_BITS  = 8,
    parameter bit   SHIFT_MSB = 1'b1,
    parameter logic IDLE_VAL  = 1'b1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     shift_enable,
    flex_pts_stream_if.slave         ld,
    output logic                     serial_out,
    output logic                     busy,
    output logic                     word_done
);

    localparam int              CW       = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(NUM_BITS);

    pts_state_t          state;
    logic [NUM_BITS-1:0] sr;
    logic [NUM_BITS-1:0] sr_shifted;
    logic [NUM_BITS-1:0] hold;
    logic                hold_full;
    logic [CW-1:0]       cnt;
    logic                accept;
    logic                stuff_req;
    logic                word_end;

    assign ld.load_ready = !hold_full;
    assign accept        = ld.load_valid && !hold_full;
    assign busy          = (state != PTS_IDLE) || hold_full;

    always_comb begin
        if (SHIFT_MSB) begin
            sr_shifted = {sr[NUM_BITS-2:0], IDLE_VAL};
        end else begin
            sr_shifted = {IDLE_VAL, sr[NUM_BITS-1:1]};
        end
    end

    always_comb begin
        if (state == PTS_IDLE) begin
            serial_out = IDLE_VAL;
        end else if (state == PTS_STUFF) begin
            serial_out = 1'b0;
        end else begin
            serial_out = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];
        end
    end

`ifdef FLEX_PTS_BIT_STUFF_EN
    // The counter sits at zero throughout IDLE, which covers "cleared on
    // entering IDLE" without needing the next-state decode.
    pts_stuff_ctrl u_stuff_ctrl (
        .clk       (clk),
        .n_rst     (n_rst),
        .count_en  ((state == PTS_SHIFT) && shift_enable),
        .bit_in    (serial_out),
        .stuff_clr (clear || (state == PTS_IDLE) ||
                    ((state == PTS_STUFF) && shift_enable)),
        .stuff_req (stuff_req)
    );
`else
    assign stuff_req = 1'b0;
`endif

    // A word ends on its last data strobe, unless that bit triggers a stuff
    // bit; the trailing stuff bit then belongs to the word (cnt already 0).
    assign word_end = shift_enable &&
                      (((state == PTS_SHIFT) && (cnt == CW'(1)) && !stuff_req) ||
                       ((state == PTS_STUFF) && (cnt == '0)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= PTS_IDLE;
            sr        <= {NUM_BITS{IDLE_VAL}};
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else if (clear) begin
            state     <= PTS_IDLE;
            sr        <= {NUM_BITS{IDLE_VAL}};
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;

            case (state)
                PTS_IDLE: begin
                    if (accept) begin
                        sr    <= ld.parallel_in;
                        cnt   <= CNT_FULL;
                        state <= PTS_SHIFT;
                    end
                end
                PTS_SHIFT: begin
                    if (shift_enable) begin
                        sr  <= sr_shifted;
                        cnt <= cnt - CW'(1);
                        if (stuff_req) begin
                            state <= PTS_STUFF;
                        end
                    end
                end
                PTS_STUFF: begin
                    if (shift_enable && (cnt != '0)) begin
                        state <= PTS_SHIFT;
                    end
                end
                default: state <= PTS_IDLE;
            endcase

            // Word completion overrides the per-state updates above: reload
            // from hold first, else take a word offered on this very edge.
            if (word_end) begin
                word_done <= 1'b1;
                if (hold_full) begin
                    sr        <= hold;
                    hold_full <= 1'b0;
                    cnt       <= CNT_FULL;
                    state     <= PTS_SHIFT;
                end else if (accept) begin
                    sr    <= ld.parallel_in;
                    cnt   <= CNT_FULL;
                    state <= PTS_SHIFT;
                end else begin
                    state <= PTS_IDLE;
                end
            end else if (accept && (state != PTS_IDLE)) begin
                hold      <= ld.parallel_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flex_pts_stream.sv
// Self-checking bench for flex_pts_stream (NUM_BITS=8, MSB first, idle 1).
// Directed cycle tables, a few hand-written corner sequences, then random
// traffic against a bit-queue reference model.
module tb_flex_pts_stream;

`ifdef FLEX_PTS_BIT_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic clear = 1'b0;
    logic shift_enable = 1'b0;
    logic serial_out, busy, word_done;

    flex_pts_stream_if #(.NUM_BITS(8)) ld_if ();

    flex_pts_stream #(
        .NUM_BITS  (8),
        .SHIFT_MSB (1'b1),
        .IDLE_VAL  (1'b1)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .shift_enable (shift_enable),
        .ld           (ld_if),
        .serial_out   (serial_out),
        .busy         (busy),
        .word_done    (word_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       clr, se, lv;
        logic [7:0] d;
        logic       e_ser, e_rdy, e_busy, e_done;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic clr, se, lv, input logic [7:0] d,
                                input logic es, er, eb, ed);
        vec_t v;
        v.clr = clr; v.se = se; v.lv = lv; v.d = d;
        v.e_ser = es; v.e_rdy = er; v.e_busy = eb; v.e_done = ed;
        tv.push_back(v);
    endfunction

    function automatic void build_table();
        logic [7:0] w, w2;
        // single word A5, strobe every cycle
        w = 8'hA5;
        add(0, 1, 1, w, 1, 1, 0, 0);
        for (int i = 7; i >= 0; i--) add(0, 1, 0, 8'h00, w[i], 1, 1, 0);
        add(0, 0, 0, 8'h00, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0);
        // A5 then 3C offered during bit 2 -> held, zero-gap reload
        w = 8'hA5; w2 = 8'h3C;
        add(0, 0, 1, w, 1, 1, 0, 0);
        add(0, 1, 0, 8'h00, w[7], 1, 1, 0);
        add(0, 1, 1, w2, w[6], 1, 1, 0);
        for (int i = 5; i >= 0; i--) add(0, 1, 0, 8'h00, w[i], 0, 1, 0);
        for (int i = 7; i >= 0; i--) add(0, 1, 0, 8'h00, w2[i], 1, 1, (i == 7));
        add(0, 0, 0, 8'h00, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0);
        // 5A then C3 offered exactly on the last-bit edge with hold empty
        w = 8'h5A; w2 = 8'hC3;
        add(0, 0, 1, w, 1, 1, 0, 0);
        for (int i = 7; i >= 1; i--) add(0, 1, 0, 8'h00, w[i], 1, 1, 0);
        add(0, 1, 1, w2, w[0], 1, 1, 0);
        for (int i = 7; i >= 0; i--) add(0, 1, 0, 8'h00, w2[i], 1, 1, (i == 7));
        add(0, 0, 0, 8'h00, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0);
        // 81 with a strobe every 4th cycle
        w = 8'h81;
        add(0, 0, 1, w, 1, 1, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            for (int k = 0; k < 3; k++) add(0, 0, 0, 8'h00, w[i], 1, 1, 0);
            add(0, 1, 0, 8'h00, w[i], 1, 1, 0);
        end
        add(0, 0, 0, 8'h00, 1, 1, 0, 1);
        add(0, 0, 0, 8'h00, 1, 1, 0, 0);
        // clear after 3 bits of 00 with F0 in the hold buffer
        add(0, 0, 1, 8'h00, 1, 1, 0, 0);
        add(0, 1, 1, 8'hF0, 0, 1, 1, 0);
        add(0, 1, 0, 8'h00, 0, 0, 1, 0);
        add(0, 1, 0, 8'h00, 0, 0, 1, 0);
        add(1, 1, 0, 8'h00, 0, 0, 1, 0);
        for (int k = 0; k < 10; k++) add(0, 1, 0, 8'h00, 1, 1, 0, 0);
    endfunction

    // ---------------- reference model ----------------
    typedef struct { bit b; bit last; } mbit_t;
    mbit_t q[$];
    int    inflight   = 0;
    int    run        = 0;
    bit    stuff_pend = 0;
    bit    stuff_end  = 0;
    bit    exp_done   = 0;

    task automatic rnd_cycle(input bit allow_load, input bit force_se);
        bit         exp_busy, exp_ser, se, lv, acc;
        logic [7:0] d;
        mbit_t      m;
        @(negedge clk);
        exp_busy = (q.size() != 0) || stuff_pend;
        if (!exp_busy)      exp_ser = 1'b1;
        else if (stuff_pend) exp_ser = 1'b0;
        else                exp_ser = q[0].b;
        chk("rnd busy", busy, exp_busy);
        chk("rnd load_ready", ld_if.load_ready, inflight < 2);
        chk("rnd word_done", word_done, exp_done);
        chk("rnd serial_out", serial_out, exp_ser);

        se = force_se ? 1'b1 : bit'($urandom_range(0, 1));
        lv = allow_load && ($urandom_range(0, 2) == 0);
        d  = 8'($urandom);
        shift_enable       = se;
        ld_if.load_valid   = lv;
        ld_if.parallel_in  = d;

        acc      = lv && (inflight < 2);
        exp_done = 0;
        if (se && exp_busy) begin
            if (stuff_pend) begin
                stuff_pend = 0;
                run = 0;
                if (stuff_end) begin exp_done = 1; inflight--; end
            end else begin
                m = q.pop_front();
                run = m.b ? run + 1 : 0;
                if (STUFF_ON && run == 6) begin
                    stuff_pend = 1;
                    stuff_end  = m.last;
                end else if (m.last) begin
                    exp_done = 1;
                    inflight--;
                end
            end
        end
        if (acc) begin
            for (int i = 7; i >= 0; i--) begin
                m.b = d[i]; m.last = (i == 0);
                q.push_back(m);
            end
            inflight++;
        end
        if (q.size() == 0 && !stuff_pend) run = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seq[$];
        int dn;
        bit fin;

        ld_if.load_valid  = 1'b0;
        ld_if.parallel_in = 8'h00;

        // reset values
        #3;
        chk("reset serial_out", serial_out, 1);
        chk("reset load_ready", ld_if.load_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset word_done", word_done, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // directed table
        build_table();
        foreach (tv[i]) begin
            @(negedge clk);
            chk($sformatf("tv%0d serial_out", i), serial_out, tv[i].e_ser);
            chk($sformatf("tv%0d load_ready", i), ld_if.load_ready, tv[i].e_rdy);
            chk($sformatf("tv%0d busy", i), busy, tv[i].e_busy);
            chk($sformatf("tv%0d word_done", i), word_done, tv[i].e_done);
            clear             = tv[i].clr;
            shift_enable      = tv[i].se;
            ld_if.load_valid  = tv[i].lv;
            ld_if.parallel_in = tv[i].d;
        end
        @(negedge clk);
        clear = 0; shift_enable = 0; ld_if.load_valid = 0;

        // asynchronous reset mid-word with the hold buffer occupied
        ld_if.load_valid = 1; ld_if.parallel_in = 8'h00;
        @(negedge clk);
        ld_if.parallel_in = 8'hF0; shift_enable = 1;
        @(negedge clk);
        ld_if.load_valid = 0; shift_enable = 0;
        chk("pre-reset serial_out", serial_out, 0);
        chk("pre-reset load_ready", ld_if.load_ready, 0);
        #2 n_rst = 1'b0;
        #1;
        chk("async reset serial_out", serial_out, 1);
        chk("async reset load_ready", ld_if.load_ready, 1);
        chk("async reset busy", busy, 0);
        chk("async reset word_done", word_done, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // two FF words back-to-back: stuffing check
        @(negedge clk);
        ld_if.load_valid = 1; ld_if.parallel_in = 8'hFF; shift_enable = 1;
        dn = 0; fin = 0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (word_done) dn++;
            if (busy) seq.push_back(serial_out);
            else fin = 1;
            ld_if.load_valid = (c == 0);
        end
        shift_enable = 0; ld_if.load_valid = 0;
        chk("ff-ff finished", fin, 1);
        chk("ff-ff bit periods", seq.size(), STUFF_ON ? 18 : 16);
        chk("ff-ff word_done pulses", dn, 2);
        foreach (seq[k])
            chk($sformatf("ff-ff period %0d", k), seq[k],
                STUFF_ON ? ((k == 6 || k == 13) ? 0 : 1) : 1);

        // random traffic against the model
        @(negedge clk);
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1, 1'b0);
        fin = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            rnd_cycle(1'b0, 1'b1);
            fin = (q.size() == 0) && !stuff_pend && !exp_done;
        end
        chk("drain finished", fin, 1);
        rnd_cycle(1'b0, 1'b0);
        rnd_cycle(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
